layer_weight_store: RTL and testbench
=====================================

// Module: layer_weight_store
// PURPOSE
//  Parametrised, clocked weight memory for one fully-connected NN layer: NODES rows of
//  WEIGHTS_PER_NODE weights each. Weights stream in serially, one per beat, over a
//  valid/ready port. An internal packer assembles each row and commits it to flip-flop storage.
//  A registered random-access read port returns a whole row per request to the layer datapath.
//  Generalises the Layer 2 latch bank to any node/weight count, adds a sequential load FSM and
//  a defined read latency.
// PARAMETERS
//  NODES             10  number of stored rows (nodes in the layer)
//  WEIGHTS_PER_NODE  10  weights per row
//  WEIGHT_WIDTH       8  bits per weight, stored raw (no arithmetic)
//  NODE_IDX_W        $clog2(NODES), min 1   width of the row index
// PORTS
//  clk         in   1                               single clock, rising edge
//  reset       in   1                               asynchronous, active-high
//  load_start  in   1                               pulse: restart the load from row 0, slot 0
//  w_valid     in   1                               weight beat valid
//  w_data      in   WEIGHT_WIDTH                    weight beat
//  w_ready     out  1                               store accepts a beat
//  loaded      out  1                               all NODES rows have been written
//  rd_en       in   1                               read request
//  rd_node     in   NODE_IDX_W                      row to read
//  rd_data     out  WEIGHTS_PER_NODE*WEIGHT_WIDTH   row; slot 0 in the LSBs
//  rd_valid    out  1                               rd_data updated this cycle
//  rd_err      out  1                               with rd_valid: rd_node >= NODES
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE; row/slot counters=0; all storage=0;
//   w_ready=0, loaded=0, rd_data=0, rd_valid=0, rd_err=0.
//  FSM states:
//   IDLE -> LOAD on load_start.
//   LOAD -> FULL after the last slot of row NODES-1 is accepted.
//   FULL -> LOAD on load_start.
//   load_start in LOAD restarts the load: counters=0, partial row discarded.
//  w_ready=1 only in LOAD (registered state; no combinational path from w_valid).
//  Beat accepted when w_valid & w_ready. w_data goes into packer slot slot_idx; slot_idx++.
//  On the last slot (slot_idx==WEIGHTS_PER_NODE-1):
//   - The full row, including this beat, is written to bank[row_idx] on the same edge.
//   - slot_idx=0 and row_idx++.
//  The accepted beat that completes row NODES-1 also sets loaded=1 and state=FULL on that edge.
//   w_ready=0 from the next cycle.
//  load_start: loaded=0 on the next edge. A beat in the same cycle as load_start is dropped,
//   because load_start has priority. Rows already committed keep their old contents until
//   overwritten.
//  Read: rd_en sampled at edge N gives rd_data=bank[rd_node], rd_valid=1 at N+1 (1-cycle latency).
//   Without rd_en: rd_valid=0 and rd_data holds its last value.
//   Out-of-range rd_node: rd_data=0, rd_valid=1, rd_err=1.
//   Reads are legal in every state.
//  Read/write collision: a read of row R in the same cycle that row R commits returns the OLD
//   row, because storage updates at the edge.
//  Reset mid-load: everything returns to reset values, including stored rows.
//  No wrap-around: beats are never accepted past the last row.
// STRUCTURE
//  GlobalVariables.v holds the shared defines: TRUE/FALSE, the layer-wide defaults for
//  NODES/WEIGHTS_PER_NODE/WEIGHT_WIDTH, and the FSM state encodings (IDLE=0, LOAD=1, FULL=2).
//  Sub-module weight_row_packer:
//   - Inputs: clk, reset, clear, beat, data.
//   - Outputs: row, row_done.
//   - Holds slot_idx and the partial row.
//  The top holds the FSM, row_idx, the bank array and the read register.
// TESTING (NODES=4, WEIGHTS_PER_NODE=3, WEIGHT_WIDTH=8)
//  1. Reset, then idle 5 cycles -> w_ready=0, loaded=0, and a read of row 2 gives rd_data=0,
//     rd_valid=1 one cycle later.
//  2. load_start, then stream 12 beats 0x01..0x0C with w_valid held high -> loaded=1 on the edge
//     of beat 12, then w_ready=0. Read row 1 -> 0x060504; read row 3 -> 0x0C0B0A.
//  3. Random w_valid gaps (~50%), values 0xA0..0xAB -> same final contents as a gap-free load.
//     loaded rises only on the 12th accepted beat.
//  4. load_start after 5 beats (0x10..0x14):
//     - Row 0 = 0x121110, row 1 unchanged.
//     - Reload with 0x20..0x2B -> row 1 = 0x252423.
//     - A beat presented together with load_start is dropped.
//  5. Read row 0 in the same cycle its third beat (0x33) commits -> old row returned.
//     Read the next cycle -> new row returned.
//  6. rd_node=5 -> rd_err=1, rd_data=0.
//     Async reset asserted after 7 load beats -> all outputs and rows at 0 immediately;
//     w_ready stays 0 until load_start.

Source files
------------

// File: rtl/layer_weight_store_pkg.sv
// Shared constants for the layer weight store: boolean levels, layer-wide size
// defaults, FSM state encodings and an index-width helper.
package layer_weight_store_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int unsigned DEFAULT_NODES            = 10;
    localparam int unsigned DEFAULT_WEIGHTS_PER_NODE = 10;
    localparam int unsigned DEFAULT_WEIGHT_WIDTH     = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    // Index width for a count of n items, never narrower than one bit
    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_row_packer.sv
// Serial-to-parallel packer: collects one weight per beat into a row.
// Ports:
//   clk, reset     clock, async active-high reset
//   clear          discard the partial row and restart at slot 0
//   beat           accept data into the current slot
//   data           weight for the current slot
//   row            partial row merged with the current data (slot 0 in LSBs)
//   row_done       this beat fills the last slot; row is complete this cycle
module weight_row_packer
    import layer_weight_store_pkg::*;
#(
    parameter int unsigned WEIGHTS_PER_NODE = DEFAULT_WEIGHTS_PER_NODE,
    parameter int unsigned WEIGHT_WIDTH     = DEFAULT_WEIGHT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic                                 beat,
    input  logic [WEIGHT_WIDTH-1:0]              data,
    output logic [WEIGHTS_PER_NODE*WEIGHT_WIDTH-1:0] row,
    output logic                                 row_done
);

    localparam int unsigned SLOT_W = idxWidth(WEIGHTS_PER_NODE);
    localparam int unsigned ROW_W  = WEIGHTS_PER_NODE * WEIGHT_WIDTH;

    logic [SLOT_W-1:0] slotIdx;
    logic [ROW_W-1:0]  partialRow;
    logic              lastSlot;

    assign lastSlot = (32'(slotIdx) == WEIGHTS_PER_NODE - 1);
    assign row_done = beat & lastSlot;

    // Row as it would look with the current beat already in place, so the
    // completing beat can be committed on the same edge it is accepted
    always_comb begin
        row = partialRow;
        for (int i = 0; i < int'(WEIGHTS_PER_NODE); i++) begin
            if (32'(slotIdx) == 32'(i)) begin
                row[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slotIdx    <= '0;
            partialRow <= '0;
        end else if (clear) begin
            slotIdx    <= '0;
            partialRow <= '0;
        end else if (beat) begin
            if (lastSlot) begin
                slotIdx    <= '0;
                partialRow <= '0;
            end else begin
                slotIdx    <= slotIdx + SLOT_W'(1);
                partialRow <= row;
            end
        end
    end

endmodule

// File: rtl/layer_weight_store.sv
// Weight memory for one fully-connected layer: NODES rows of WEIGHTS_PER_NODE
// weights, loaded serially over valid/ready and read a whole row at a time.
// Ports:
//   clk, reset              clock, async active-high reset
//   load_start              restart the load from row 0, slot 0
//   w_valid/w_data/w_ready  serial weight stream (ready only while loading)
//   loaded                  every row has been written since the last load_start
//   rd_en/rd_node           row read request
//   rd_data/rd_valid/rd_err row result one cycle later; rd_err flags bad index
module layer_weight_store
    import layer_weight_store_pkg::*;
#(
    parameter int unsigned NODES            = DEFAULT_NODES,
    parameter int unsigned WEIGHTS_PER_NODE = DEFAULT_WEIGHTS_PER_NODE,
    parameter int unsigned WEIGHT_WIDTH     = DEFAULT_WEIGHT_WIDTH,
    parameter int unsigned NODE_IDX_W       = idxWidth(NODES)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     load_start,
    input  logic                                     w_valid,
    input  logic [WEIGHT_WIDTH-1:0]                  w_data,
    output logic                                     w_ready,
    output logic                                     loaded,
    input  logic                                     rd_en,
    input  logic [NODE_IDX_W-1:0]                    rd_node,
    output logic [WEIGHTS_PER_NODE*WEIGHT_WIDTH-1:0] rd_data,
    output logic                                     rd_valid,
    output logic                                     rd_err
);

    localparam int unsigned ROW_W = WEIGHTS_PER_NODE * WEIGHT_WIDTH;

    logic [1:0]            state;
    logic [1:0]            stateNext;
    logic [NODE_IDX_W-1:0] rowIdx;
    logic [NODE_IDX_W-1:0] rowIdxNext;
    logic                  loadedNext;
    logic                  wReadyNext;
    logic                  beat;
    logic                  rowDone;
    logic                  lastRow;
    logic [ROW_W-1:0]      packedRow;
    logic [ROW_W-1:0]      rdRow;
    logic                  rdInRange;
    logic [ROW_W-1:0]      bank [NODES];

    // load_start wins over a beat presented in the same cycle
    assign beat    = w_valid & w_ready & ~load_start;
    assign lastRow = (32'(rowIdx) == NODES - 1);

    weight_row_packer #(
        .WEIGHTS_PER_NODE (WEIGHTS_PER_NODE),
        .WEIGHT_WIDTH     (WEIGHT_WIDTH)
    ) u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (load_start),
        .beat     (beat),
        .data     (w_data),
        .row      (packedRow),
        .row_done (rowDone)
    );

    // Load FSM next-state and control
    always_comb begin
        stateNext  = state;
        rowIdxNext = rowIdx;
        loadedNext = loaded;
        case (state)
            IDLE:    if (load_start) stateNext = LOAD;
            LOAD:    if (rowDone && lastRow) stateNext = FULL;
            FULL:    if (load_start) stateNext = LOAD;
            default: stateNext = IDLE;
        endcase
        if (load_start) begin
            rowIdxNext = '0;
            loadedNext = FALSE;
        end else if (rowDone) begin
            // Stop at the last row instead of wrapping back to row 0
            if (lastRow) loadedNext = TRUE;
            else         rowIdxNext = rowIdx + NODE_IDX_W'(1);
        end
        wReadyNext = (stateNext == LOAD) ? TRUE : FALSE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rowIdx  <= '0;
            loaded  <= FALSE;
            w_ready <= FALSE;
        end else begin
            state   <= stateNext;
            rowIdx  <= rowIdxNext;
            loaded  <= loadedNext;
            w_ready <= wReadyNext;
        end
    end

    // Row commit; a same-cycle read of this row sees the pre-edge contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NODES); i++) bank[i] <= '0;
        end else if (rowDone) begin
            for (int i = 0; i < int'(NODES); i++) begin
                if (32'(rowIdx) == 32'(i)) bank[i] <= packedRow;
            end
        end
    end

    // Read mux; out-of-range index yields zero
    always_comb begin
        rdRow     = '0;
        rdInRange = (32'(rd_node) < NODES);
        for (int i = 0; i < int'(NODES); i++) begin
            if (32'(rd_node) == 32'(i)) rdRow = bank[i];
        end
    end

    // Read register: rd_data holds its last value when no request is made
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= FALSE;
            rd_err   <= FALSE;
        end else if (rd_en) begin
            rd_data  <= rdRow;
            rd_valid <= TRUE;
            rd_err   <= rdInRange ? FALSE : TRUE;
        end else begin
            rd_valid <= FALSE;
            rd_err   <= FALSE;
        end
    end

endmodule

// File: tb/tb_layer_weight_store.sv
// Directed bench for layer_weight_store with a 4x3 byte configuration; the
// index is widened to 3 bits so that row 5 can be requested.
module tb_layer_weight_store;

    localparam int unsigned NODES = 4;
    localparam int unsigned WPN   = 3;
    localparam int unsigned WW    = 8;
    localparam int unsigned IDXW  = 3;

    logic           clk;
    logic           reset;
    logic           load_start;
    logic           w_valid;
    logic [WW-1:0]  w_data;
    logic           w_ready;
    logic           loaded;
    logic           rd_en;
    logic [IDXW-1:0] rd_node;
    logic [WPN*WW-1:0] rd_data;
    logic           rd_valid;
    logic           rd_err;

    int nCompared;
    int nMismatched;

    layer_weight_store #(
        .NODES            (NODES),
        .WEIGHTS_PER_NODE (WPN),
        .WEIGHT_WIDTH     (WW),
        .NODE_IDX_W       (IDXW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .w_valid    (w_valid),
        .w_data     (w_data),
        .w_ready    (w_ready),
        .loaded     (loaded),
        .rd_en      (rd_en),
        .rd_node    (rd_node),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end just after a falling edge
    task automatic pulseLoadStart();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Present one beat until accepted, with a bounded wait
    task automatic sendBeat(input logic [WW-1:0] v, output bit ok);
        bit rdy;
        ok      = 1'b0;
        w_valid = 1'b1;
        w_data  = v;
        for (int i = 0; i < 50; i++) begin
            rdy = w_ready;
            @(negedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        w_valid = 1'b0;
    endtask

    task automatic doRead(input logic [IDXW-1:0] n, output logic [WPN*WW-1:0] d,
                          output logic v, output logic e);
        rd_en   = 1'b1;
        rd_node = n;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
        v = rd_valid;
        e = rd_err;
    endtask

    task automatic test_reset();
        logic [WPN*WW-1:0] d;
        logic v, e;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        nCompared++;
        if (w_ready !== 1'b0) begin nMismatched++; $display("FAIL reset_w_ready got=%0h exp=0", w_ready); end
        nCompared++;
        if (loaded !== 1'b0) begin nMismatched++; $display("FAIL reset_loaded got=%0h exp=0", loaded); end
        nCompared++;
        if (rd_valid !== 1'b0) begin nMismatched++; $display("FAIL reset_rd_valid got=%0h exp=0", rd_valid); end
        doRead(3'd2, d, v, e);
        nCompared++;
        if (d !== 24'h0) begin nMismatched++; $display("FAIL reset_read_data got=%06h exp=000000", d); end
        nCompared++;
        if (v !== 1'b1) begin nMismatched++; $display("FAIL reset_read_valid got=%0h exp=1", v); end
        nCompared++;
        if (e !== 1'b0) begin nMismatched++; $display("FAIL reset_read_err got=%0h exp=0", e); end
    endtask

    task automatic test_load_stream();
        logic [WPN*WW-1:0] d;
        logic v, e;
        bit ok;
        pulseLoadStart();
        nCompared++;
        if (w_ready !== 1'b1) begin nMismatched++; $display("FAIL load_w_ready_up got=%0h exp=1", w_ready); end
        for (int i = 1; i <= 12; i++) begin
            sendBeat(8'(i), ok);
            nCompared++;
            if (ok !== 1'b1) begin nMismatched++; $display("FAIL load_beat_accept beat=%0d got=%0h exp=1", i, ok); end
            if (i == 11) begin
                nCompared++;
                if (loaded !== 1'b0) begin nMismatched++; $display("FAIL load_loaded_early got=%0h exp=0", loaded); end
            end
        end
        nCompared++;
        if (loaded !== 1'b1) begin nMismatched++; $display("FAIL load_loaded got=%0h exp=1", loaded); end
        nCompared++;
        if (w_ready !== 1'b0) begin nMismatched++; $display("FAIL load_w_ready_down got=%0h exp=0", w_ready); end
        doRead(3'd1, d, v, e);
        nCompared++;
        if (d !== 24'h060504) begin nMismatched++; $display("FAIL load_row1 got=%06h exp=060504", d); end
        doRead(3'd3, d, v, e);
        nCompared++;
        if (d !== 24'h0C0B0A) begin nMismatched++; $display("FAIL load_row3 got=%06h exp=0C0B0A", d); end
        // Beats offered in FULL must not wrap into row 0
        w_valid = 1'b1;
        w_data  = 8'hFF;
        repeat (3) @(negedge clk);
        w_valid = 1'b0;
        nCompared++;
        if (w_ready !== 1'b0) begin nMismatched++; $display("FAIL full_w_ready got=%0h exp=0", w_ready); end
        doRead(3'd0, d, v, e);
        nCompared++;
        if (d !== 24'h030201) begin nMismatched++; $display("FAIL full_no_wrap_row0 got=%06h exp=030201", d); end
    endtask

    task automatic test_back_to_back();
        rd_en   = 1'b1;
        rd_node = 3'd1;
        @(negedge clk);
        nCompared++;
        if (rd_data !== 24'h060504 || rd_valid !== 1'b1) begin nMismatched++; $display("FAIL b2b_first got=%06h/%0h exp=060504/1", rd_data, rd_valid); end
        rd_node = 3'd2;
        @(negedge clk);
        nCompared++;
        if (rd_data !== 24'h090807 || rd_valid !== 1'b1) begin nMismatched++; $display("FAIL b2b_second got=%06h/%0h exp=090807/1", rd_data, rd_valid); end
        rd_en = 1'b0;
        @(negedge clk);
        nCompared++;
        if (rd_valid !== 1'b0) begin nMismatched++; $display("FAIL b2b_valid_drop got=%0h exp=0", rd_valid); end
        nCompared++;
        if (rd_data !== 24'h090807) begin nMismatched++; $display("FAIL b2b_data_hold got=%06h exp=090807", rd_data); end
    endtask

    task automatic test_gaps();
        logic [WPN*WW-1:0] d;
        logic [WPN*WW-1:0] expRow;
        logic v, e;
        bit ok;
        pulseLoadStart();
        nCompared++;
        if (loaded !== 1'b0) begin nMismatched++; $display("FAIL gaps_loaded_clear got=%0h exp=0", loaded); end
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            sendBeat(8'(8'hA0 + i), ok);
            nCompared++;
            if (ok !== 1'b1) begin nMismatched++; $display("FAIL gaps_beat_accept beat=%0d got=%0h exp=1", i, ok); end
            nCompared++;
            if (loaded !== ((i == 11) ? 1'b1 : 1'b0)) begin nMismatched++; $display("FAIL gaps_loaded beat=%0d got=%0h", i, loaded); end
        end
        for (int r = 0; r < 4; r++) begin
            expRow = {8'(8'hA0 + 3*r + 2), 8'(8'hA0 + 3*r + 1), 8'(8'hA0 + 3*r)};
            doRead(3'(r), d, v, e);
            nCompared++;
            if (d !== expRow) begin nMismatched++; $display("FAIL gaps_row%0d got=%06h exp=%06h", r, d, expRow); end
        end
    endtask

    task automatic test_restart();
        logic [WPN*WW-1:0] d;
        logic v, e;
        bit ok;
        pulseLoadStart();
        for (int i = 0; i < 5; i++) sendBeat(8'(8'h10 + i), ok);
        doRead(3'd0, d, v, e);
        nCompared++;
        if (d !== 24'h121110) begin nMismatched++; $display("FAIL restart_row0 got=%06h exp=121110", d); end
        doRead(3'd1, d, v, e);
        nCompared++;
        if (d !== 24'hA5A4A3) begin nMismatched++; $display("FAIL restart_row1_kept got=%06h exp=A5A4A3", d); end
        // Beat alongside load_start is dropped
        load_start = 1'b1;
        w_valid    = 1'b1;
        w_data     = 8'hEE;
        @(negedge clk);
        load_start = 1'b0;
        w_valid    = 1'b0;
        nCompared++;
        if (w_ready !== 1'b1) begin nMismatched++; $display("FAIL restart_w_ready got=%0h exp=1", w_ready); end
        for (int i = 0; i < 12; i++) sendBeat(8'(8'h20 + i), ok);
        nCompared++;
        if (loaded !== 1'b1) begin nMismatched++; $display("FAIL restart_loaded got=%0h exp=1", loaded); end
        doRead(3'd0, d, v, e);
        nCompared++;
        if (d !== 24'h222120) begin nMismatched++; $display("FAIL restart_drop_row0 got=%06h exp=222120", d); end
        doRead(3'd1, d, v, e);
        nCompared++;
        if (d !== 24'h252423) begin nMismatched++; $display("FAIL restart_row1 got=%06h exp=252423", d); end
    endtask

    task automatic test_collision();
        bit ok;
        pulseLoadStart();
        sendBeat(8'h31, ok);
        sendBeat(8'h32, ok);
        w_valid = 1'b1;
        w_data  = 8'h33;
        rd_en   = 1'b1;
        rd_node = 3'd0;
        @(negedge clk);
        w_valid = 1'b0;
        nCompared++;
        if (rd_data !== 24'h222120 || rd_valid !== 1'b1) begin nMismatched++; $display("FAIL collide_old got=%06h/%0h exp=222120/1", rd_data, rd_valid); end
        @(negedge clk);
        rd_en = 1'b0;
        nCompared++;
        if (rd_data !== 24'h333231) begin nMismatched++; $display("FAIL collide_new got=%06h exp=333231", rd_data); end
    endtask

    task automatic test_err_and_async_reset();
        logic [WPN*WW-1:0] d;
        logic v, e;
        bit ok;
        doRead(3'd5, d, v, e);
        nCompared++;
        if (d !== 24'h0 || v !== 1'b1 || e !== 1'b1) begin nMismatched++; $display("FAIL oob_read got=%06h/%0h/%0h exp=000000/1/1", d, v, e); end
        doRead(3'd0, d, v, e);
        nCompared++;
        if (d !== 24'h333231 || e !== 1'b0) begin nMismatched++; $display("FAIL inrange_after_oob got=%06h/%0h exp=333231/0", d, e); end
        pulseLoadStart();
        for (int i = 0; i < 7; i++) sendBeat(8'(8'h40 + i), ok);
        rd_en   = 1'b1;
        rd_node = 3'd1;
        @(negedge clk);
        nCompared++;
        if (rd_data !== 24'h454443 || rd_valid !== 1'b1) begin nMismatched++; $display("FAIL pre_reset_read got=%06h/%0h exp=454443/1", rd_data, rd_valid); end
        // Assert reset between clock edges
        #2;
        reset = 1'b1;
        rd_en = 1'b0;
        #1;
        nCompared++;
        if (w_ready !== 1'b0 || loaded !== 1'b0) begin nMismatched++; $display("FAIL async_reset_ctrl got=%0h/%0h exp=0/0", w_ready, loaded); end
        nCompared++;
        if (rd_data !== 24'h0 || rd_valid !== 1'b0 || rd_err !== 1'b0) begin nMismatched++; $display("FAIL async_reset_read got=%06h/%0h/%0h exp=000000/0/0", rd_data, rd_valid, rd_err); end
        @(negedge clk);
        reset   = 1'b0;
        w_valid = 1'b1;
        w_data  = 8'h99;
        repeat (3) @(negedge clk);
        w_valid = 1'b0;
        nCompared++;
        if (w_ready !== 1'b0) begin nMismatched++; $display("FAIL post_reset_w_ready got=%0h exp=0", w_ready); end
        for (int r = 0; r < 4; r++) begin
            doRead(3'(r), d, v, e);
            nCompared++;
            if (d !== 24'h0) begin nMismatched++; $display("FAIL post_reset_row%0d got=%06h exp=000000", r, d); end
        end
        pulseLoadStart();
        nCompared++;
        if (w_ready !== 1'b1) begin nMismatched++; $display("FAIL post_reset_reload got=%0h exp=1", w_ready); end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset       = 1'b1;
        load_start  = 1'b0;
        w_valid     = 1'b0;
        w_data      = '0;
        rd_en       = 1'b0;
        rd_node     = '0;
        test_reset();
        test_load_stream();
        test_back_to_back();
        test_gaps();
        test_restart();
        test_collision();
        test_err_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
